// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with valid/ready handshakes,
// multiply, iterative restoring divide, result flags and output hold.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_FUN,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [2*WIDTH-1:0] ALU_OUT,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               ZERO_FLAG,
    output logic               CARRY_FLAG,
    output logic               DIV_ERR,
    output logic               BUSY
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_EQ   = 4'hA;
    localparam logic [3:0] OP_GT   = 4'hB;
    localparam logic [3:0] OP_LT   = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_SHL  = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic             in_ready_c;
    logic             busy_c;
    logic             accept;
    logic             release_o;
    logic             div_start;
    logic             div_last;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [RW-1:0]    res_c;
    logic             carry_c;
    logic             err_c;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   trial_sub;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    logic [RW-1:0]    out_q;
    logic             out_valid;
    logic             zero_q;
    logic             carry_q;
    logic             err_q;

    assign accept    = IN_VALID & in_ready_c;
    assign release_o = out_valid & OUT_READY;
    assign div_start = accept & (ALU_FUN == OP_DIV) & (B != '0);
    assign div_last  = (state == S_DIV) & (cnt == LAST);

    assign sum = {1'b0, A} + {1'b0, B};
    assign dif = {1'b0, A} - {1'b0, B};

    // one restoring step: shift in the next dividend bit, subtract if it fits
    assign trial     = {rem, quo[WIDTH-1]};
    assign trial_sub = trial - {1'b0, dvs};
    assign rem_nx    = trial_sub[WIDTH] ? trial[WIDTH-1:0] : trial_sub[WIDTH-1:0];
    assign quo_nx    = {quo[WIDTH-2:0], ~trial_sub[WIDTH]};

    assign IN_READY   = in_ready_c;
    assign BUSY       = busy_c;
    assign ALU_OUT    = out_q;
    assign OUT_VALID  = out_valid;
    assign ZERO_FLAG  = zero_q;
    assign CARRY_FLAG = carry_q;
    assign DIV_ERR    = err_q;

    // single-cycle result and flags for the operation being offered
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        err_c   = 1'b0;
        case (ALU_FUN)
            OP_ADD: begin
                res_c   = {{(WIDTH-1){1'b0}}, sum};
                carry_c = sum[WIDTH];
            end
            OP_SUB: begin
                res_c   = {{(WIDTH-1){1'b0}}, dif};
                carry_c = dif[WIDTH];
            end
            OP_MUL:  res_c = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
            OP_DIV: begin
                res_c = {A, {WIDTH{1'b1}}};
                err_c = (B == '0);
            end
            OP_AND:  res_c = {{WIDTH{1'b0}}, A & B};
            OP_OR:   res_c = {{WIDTH{1'b0}}, A | B};
            OP_NAND: res_c = {{WIDTH{1'b0}}, ~(A & B)};
            OP_NOR:  res_c = {{WIDTH{1'b0}}, ~(A | B)};
            OP_XOR:  res_c = {{WIDTH{1'b0}}, A ^ B};
            OP_XNOR: res_c = {{WIDTH{1'b0}}, ~(A ^ B)};
            OP_EQ:   res_c[0] = (A == B);
            OP_GT:   res_c[1] = (A > B);
            OP_LT:   res_c[1:0] = (A < B) ? 2'd3 : 2'd0;
            OP_SHR:  res_c = {{WIDTH{1'b0}}, 1'b0, A[WIDTH-1:1]};
            OP_SHL:  res_c = {{WIDTH{1'b0}}, A[WIDTH-2:0], 1'b0};
            default: res_c = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    // FSM next state: a release cycle may also accept, as if from IDLE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_OUT: begin
                if (accept)
                    state_nx = div_start ? S_DIV : S_OUT;
                else if (state == S_OUT && release_o)
                    state_nx = S_IDLE;
            end
            S_DIV: begin
                if (cnt == LAST) state_nx = S_OUT;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: ready outside divide when the result slot frees up
    always_comb begin
        busy_c     = (state == S_DIV);
        in_ready_c = ~RST & (state != S_DIV) & (~out_valid | OUT_READY);
    end

    // result, flag and divider registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q     <= '0;
            out_valid <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            cnt       <= '0;
        end else begin
            if (release_o) out_valid <= 1'b0;
            if (accept && !div_start) begin
                out_q     <= res_c;
                zero_q    <= (res_c == '0);
                carry_q   <= carry_c;
                err_q     <= err_c;
                out_valid <= 1'b1;
            end
            if (div_start) begin
                rem <= '0;
                quo <= A;
                dvs <= B;
                cnt <= '0;
            end else if (state == S_DIV) begin
                rem <= rem_nx;
                quo <= quo_nx;
                cnt <= cnt + 1'b1;
                if (div_last) begin
                    out_q     <= {rem_nx, quo_nx};
                    zero_q    <= ({rem_nx, quo_nx} == '0);
                    carry_q   <= 1'b0;
                    err_q     <= 1'b0;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
